// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampling I2S ADC deserialiser producing left/right sample pairs with a valid strobe.
// Define I2S_RX_ERROR_COUNT_EN to add a saturating 16-bit frame error counter output.
module i2s_receiver #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic                    i_codec_bit_clock,
    input  logic                    i_codec_lr_clock,
    input  logic                    i_codec_adc_data,
    output logic [SAMPLE_WIDTH-1:0] o_left_sample,
    output logic [SAMPLE_WIDTH-1:0] o_right_sample,
    output logic                    o_sample_valid,
    output logic                    o_frame_error
`ifdef I2S_RX_ERROR_COUNT_EN
    ,
    output logic [15:0]             o_error_count
`endif
);
    localparam int CW = $clog2(SLOT_WIDTH + 1);
    localparam logic [CW-1:0] SLOT = CW'(SLOT_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(SLOT_WIDTH - 1);
    localparam logic [CW-1:0] SMAX = CW'(SAMPLE_WIDTH);

    logic [1:0]              bclk_sync_q, lr_sync_q, data_sync_q;
    logic                    bclk_prev_q, lr_prev_q, lr_prev_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d, hold_q, hold_d;
    logic [SAMPLE_WIDTH-1:0] left_q, left_d, right_q, right_d;
    logic                    left_ok_q, left_ok_d, valid_q, err_q;
    logic                    rise, lr, change, good, bad, fire;

    assign rise   = bclk_sync_q[1] & ~bclk_prev_q;
    assign lr     = lr_sync_q[1];
    assign change = rise & (lr != lr_prev_q);
    assign good   = change & (cnt_q == LAST);
    // A saturated count means no alignment yet, so that slot is dropped without an error
    assign bad    = change & (cnt_q < LAST);
    assign fire   = good & lr_prev_q & left_ok_q;

    always_comb begin
        lr_prev_d = rise ? lr : lr_prev_q;
        cnt_d     = !rise ? cnt_q : change ? '0 : (cnt_q == SLOT) ? cnt_q : cnt_q + 1'b1;
        shift_d   = (rise && cnt_d != '0 && cnt_d <= SMAX) ? SAMPLE_WIDTH'({shift_q, data_sync_q[1]}) : shift_q;
        hold_d    = (good && !lr_prev_q) ? shift_q : hold_q;
        left_ok_d = (good && !lr_prev_q) ? 1'b1 : change ? 1'b0 : left_ok_q;
        left_d    = fire ? hold_q : left_q;
        right_d   = fire ? shift_q : right_q;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            data_sync_q <= '0;
            bclk_prev_q <= 1'b0;
            lr_prev_q   <= 1'b0;
            cnt_q       <= SLOT;
            shift_q     <= '0;
            hold_q      <= '0;
            left_ok_q   <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[0], i_codec_bit_clock};
            lr_sync_q   <= {lr_sync_q[0], i_codec_lr_clock};
            data_sync_q <= {data_sync_q[0], i_codec_adc_data};
            bclk_prev_q <= bclk_sync_q[1];
            lr_prev_q   <= lr_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            left_ok_q   <= left_ok_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= fire;
            err_q       <= bad;
        end
    end

    assign o_left_sample  = left_q;
    assign o_right_sample = right_q;
    assign o_sample_valid = valid_q;
    assign o_frame_error  = err_q;

`ifdef I2S_RX_ERROR_COUNT_EN
    logic [15:0] ecnt_q, ecnt_d;

    assign ecnt_d = (err_q && ecnt_q != 16'hFFFF) ? ecnt_q + 16'd1 : ecnt_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) ecnt_q <= '0;
        else            ecnt_q <= ecnt_d;
    end

    assign o_error_count = ecnt_q;
`endif
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: scoreboard bench driving I2S frames and checking sample pairs, errors and latency.
module tb_i2s_receiver;
    localparam int SW = 24;

    logic clk = 1'b0, rst_n = 1'b0, bclk = 1'b0, lrc = 1'b0, dat = 1'b0;
    logic [SW-1:0] l_o, r_o;
    logic valid_o, err_o;
`ifdef I2S_RX_ERROR_COUNT_EN
    logic [15:0] ecnt_o;
`endif

    i2s_receiver #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(32)) dut (
        .i_clock(clk),
        .i_reset_n(rst_n),
        .i_codec_bit_clock(bclk),
        .i_codec_lr_clock(lrc),
        .i_codec_adc_data(dat),
        .o_left_sample(l_o),
        .o_right_sample(r_o),
        .o_sample_valid(valid_o),
        .o_frame_error(err_o)
`ifdef I2S_RX_ERROR_COUNT_EN
        ,
        .o_error_count(ecnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, err_seen = 0, cyc = 0, last_rise = 0;
    logic [47:0] q[$];
    logic [SW-1:0] hold_l, hold_r;
    logic v_prev, e_prev;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_slot(input bit ch, input logic [SW-1:0] s, input int len, input bit fill, input int half);
        for (int i = 0; i < len; i++) begin
            repeat (half) @(posedge clk);
            #1 bclk = 1'b0;
            lrc = ch;
            dat = (i >= 1 && i <= SW) ? s[SW-i] : fill;
            repeat (half) @(posedge clk);
            #1 bclk = 1'b1;
            last_rise = cyc;
        end
    endtask

    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input int ll, input int rl,
                              input bit fill, input int half, input bit expv);
        send_slot(1'b0, l, ll, fill, half);
        send_slot(1'b1, r, rl, fill, half);
        if (expv) q.push_back({l, r});
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_l = '0;
            hold_r = '0;
            v_prev = 1'b0;
            e_prev = 1'b0;
        end else begin
            if (valid_o) begin
                check("valid_width", v_prev, 1'b0);
                check("valid_err_excl", err_o, 1'b0);
                check("valid_expected", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    logic [47:0] e;
                    e = q.pop_front();
                    check("left", l_o, e[47:24]);
                    check("right", r_o, e[23:0]);
                    check("latency_3to5", (cyc - last_rise >= 3) && (cyc - last_rise <= 5), 1'b1);
                    hold_l = e[47:24];
                    hold_r = e[23:0];
                end
            end else begin
                check("hold", {l_o, r_o}, {hold_l, hold_r});
            end
            if (err_o) begin
                err_seen++;
                check("err_width", e_prev, 1'b0);
            end
            v_prev = valid_o;
            e_prev = err_o;
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        check("rst_left", l_o, 0);
        check("rst_right", r_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_err", err_o, 0);
        #1 rst_n = 1'b1;
        send_frame(24'h123456, 24'hABCDEF, 32, 32, 1'b0, 16, 1'b0);
        send_frame(24'h123456, 24'hABCDEF, 32, 32, 1'b0, 16, 1'b1);
        send_frame(24'h123456, 24'hABCDEF, 32, 32, 1'b0, 16, 1'b1);
        send_frame(24'h800000, 24'h7FFFFF, 32, 32, 1'b1, 16, 1'b1);
        check("clean_no_err", err_seen, 0);
        send_frame(24'h111111, 24'h222222, 30, 32, 1'b0, 16, 1'b0);
        send_frame(24'h333333, 24'h444444, 32, 28, 1'b0, 16, 1'b0);
        send_frame(24'h555555, 24'h666666, 31, 32, 1'b0, 16, 1'b0);
        send_frame(24'h13579B, 24'h2468AC, 32, 32, 1'b0, 16, 1'b1);
        send_slot(1'b0, 24'h0F0F0F, 32, 1'b0, 16);
        send_slot(1'b1, 24'h0F0F0F, 16, 1'b0, 16);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_left", l_o, 0);
        check("mid_rst_right", r_o, 0);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_queue", q.size(), 0);
        q.delete();
        bclk = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(24'hDEAD01, 24'hBEEF02, 32, 32, 1'b0, 16, 1'b0);
        send_frame(24'hC0FFEE, 24'h0BADF0, 32, 32, 1'b0, 16, 1'b1);
        send_frame(24'h000001, 24'hFFFFFE, 32, 32, 1'b0, 3, 1'b1);
        send_slot(1'b0, 24'h0, 2, 1'b0, 3);
        repeat (40) @(posedge clk);
        check("queue_drained", q.size(), 0);
        check("err_pulses", err_seen, 3);
`ifdef I2S_RX_ERROR_COUNT_EN
        check("err_count", ecnt_o, 16'd3);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
